tablero_jugadas: RTL and testbench

//  Move-acceptance end of the position-selector interface for the 3x3 tic-tac-toe VGA lab.

---
 rtl/tablero_jugadas_if.sv | 37 +++
 rtl/tablero_jugadas.sv | 165 ++++++++++++++++
 tb/tb_tablero_jugadas.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/tablero_jugadas_if.sv
// Selector/board bus for the tic-tac-toe move acceptor: the selector drives pos/ready/new_game,
// the board side returns the board, turn, result and the selector re-arm pulses.
interface tablero_jugadas_if;
   logic [3:0]  pos;
   logic        ready;
   logic        new_game;
   logic [17:0] board;
   logic        turn;
   logic [1:0]  winner;
   logic        game_over;
   logic        sel_clr;
   logic        move_err;

   modport master (
      output pos,
      output ready,
      output new_game,
      input  board,
      input  turn,
      input  winner,
      input  game_over,
      input  sel_clr,
      input  move_err
   );

   modport slave (
      input  pos,
      input  ready,
      input  new_game,
      output board,
      output turn,
      output winner,
      output game_over,
      output sel_clr,
      output move_err
   );
endinterface

// File: rtl/tablero_jugadas.sv
// 3x3 tic-tac-toe move acceptor: validates selector confirms, writes marks, alternates turns and
// detects win/draw. Optional turn timeout is built when TURN_TIMEOUT_EN is defined.
module tablero_jugadas #(
   parameter int unsigned N_CELLS        = 9,
   parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
   input logic              clk,
   input logic              reset,
   tablero_jugadas_if.slave bus
);

   localparam logic [1:0] MarkX   = 2'b01;
   localparam logic [1:0] MarkO   = 2'b10;
   localparam logic [1:0] ResNone = 2'b00;
   localparam logic [1:0] ResDraw = 2'b11;
   localparam logic [3:0] MaxMoves = 4'(N_CELLS);

   typedef enum logic [1:0] {StWait, StEval, StOver} state_e;

   state_e      state_q, state_d;
   logic [17:0] board_q, board_d;
   logic        turn_q, turn_d;
   logic [1:0]  winner_q, winner_d;
   logic        game_over_q, game_over_d;
   logic [3:0]  moves_q, moves_d;
   logic        sel_clr_q, sel_clr_d;
   logic        move_err_q, move_err_d;
   logic        ready_q;

   logic        confirm;
   logic        pos_ok;
   logic        cell_empty;
   logic [1:0]  mark;
   logic        line_win;

`ifdef TURN_TIMEOUT_EN
   logic [27:0] timer_q, timer_d;
`endif

   function automatic logic hit(logic [17:0] b, logic [1:0] m, int a, int c, int d);
      return (b[2*a +: 2] == m) && (b[2*c +: 2] == m) && (b[2*d +: 2] == m);
   endfunction

   assign confirm = bus.ready & ~ready_q;
   assign pos_ok  = bus.pos < 4'(N_CELLS);
   assign mark    = turn_q ? MarkO : MarkX;

   always_comb begin
      cell_empty = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (bus.pos == 4'(i)) cell_empty = (board_q[2*i +: 2] == 2'b00);
      end
   end

   // Only the player who just moved can have completed a line.
   assign line_win = hit(board_q, mark, 0, 1, 2) | hit(board_q, mark, 3, 4, 5) |
                     hit(board_q, mark, 6, 7, 8) | hit(board_q, mark, 0, 3, 6) |
                     hit(board_q, mark, 1, 4, 7) | hit(board_q, mark, 2, 5, 8) |
                     hit(board_q, mark, 0, 4, 8) | hit(board_q, mark, 2, 4, 6);

   always_comb begin
      state_d     = state_q;
      board_d     = board_q;
      turn_d      = turn_q;
      winner_d    = winner_q;
      game_over_d = game_over_q;
      moves_d     = moves_q;
      sel_clr_d   = 1'b0;
      move_err_d  = 1'b0;

      if (bus.new_game) begin
         state_d     = StWait;
         board_d     = '0;
         turn_d      = 1'b0;
         winner_d    = ResNone;
         game_over_d = 1'b0;
         moves_d     = '0;
      end else begin
         unique case (state_q)
            StWait: begin
               if (confirm) begin
                  sel_clr_d = 1'b1;
                  if (pos_ok && cell_empty) begin
                     for (int i = 0; i < 9; i++) begin
                        if (bus.pos == 4'(i)) board_d[2*i +: 2] = mark;
                     end
                     moves_d = (moves_q >= MaxMoves) ? MaxMoves : moves_q + 4'd1;
                     state_d = StEval;
                  end else begin
                     move_err_d = 1'b1;
                  end
               end
            end
            StEval: begin
               if (line_win) begin
                  winner_d    = mark;
                  game_over_d = 1'b1;
                  state_d     = StOver;
               end else if (moves_q == MaxMoves) begin
                  winner_d    = ResDraw;
                  game_over_d = 1'b1;
                  state_d     = StOver;
               end else begin
                  turn_d  = ~turn_q;
                  state_d = StWait;
               end
            end
            StOver: begin
               if (confirm) sel_clr_d = 1'b1;
            end
            default: state_d = StWait;
         endcase
      end

`ifdef TURN_TIMEOUT_EN
      timer_d = '0;
      if (!bus.new_game && state_q == StWait && !confirm) begin
         if (timer_q == 28'(TIMEOUT_CYCLES - 1)) begin
            turn_d = ~turn_q;
         end else begin
            timer_d = timer_q + 28'd1;
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StWait;
         board_q     <= '0;
         turn_q      <= 1'b0;
         winner_q    <= ResNone;
         game_over_q <= 1'b0;
         moves_q     <= '0;
         sel_clr_q   <= 1'b0;
         move_err_q  <= 1'b0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         board_q     <= board_d;
         turn_q      <= turn_d;
         winner_q    <= winner_d;
         game_over_q <= game_over_d;
         moves_q     <= moves_d;
         sel_clr_q   <= sel_clr_d;
         move_err_q  <= move_err_d;
         ready_q     <= bus.ready;
      end
   end

`ifdef TURN_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (reset) timer_q <= '0;
      else       timer_q <= timer_d;
   end
`endif

   assign bus.board     = board_q;
   assign bus.turn      = turn_q;
   assign bus.winner    = winner_q;
   assign bus.game_over = game_over_q;
   assign bus.sel_clr   = sel_clr_q;
   assign bus.move_err  = move_err_q;

endmodule

// File: tb/tb_tablero_jugadas.sv
// Directed bench for tablero_jugadas: per-cycle vector table plus hand sequences for reset
// corners and (with TURN_TIMEOUT_EN) the turn timeout.
module tb_tablero_jugadas;

   localparam logic [1:0] X = 2'b01;
   localparam logic [1:0] O = 2'b10;

   typedef struct {
      string       name;
      logic [3:0]  pos;
      logic        rdy;
      logic        ng;
      logic [17:0] board;
      logic        turn;
      logic [1:0]  winner;
      logic        go;
      logic        sc;
      logic        me;
   } vec_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   vec_t vecs[$];

   tablero_jugadas_if bus();

   tablero_jugadas #(
      .N_CELLS       (9),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [17:0] cl(int i, logic [1:0] m);
      logic [17:0] r;
      r = '0;
      r[2*i +: 2] = m;
      return r;
   endfunction

   task automatic check(string name, logic [23:0] got, logic [23:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got {board,turn,winner,go,sc,me}=%h expected %h", name, got, exp);
      end
   endtask

   function automatic logic [23:0] outs();
      return {bus.board, bus.turn, bus.winner, bus.game_over, bus.sel_clr, bus.move_err};
   endfunction

   task automatic add(string n, logic [3:0] p, logic r, logic g, logic [17:0] b, logic t,
                      logic [1:0] w, logic go, logic sc, logic me);
      vec_t v;
      v.name = n; v.pos = p; v.rdy = r; v.ng = g; v.board = b; v.turn = t;
      v.winner = w; v.go = go; v.sc = sc; v.me = me;
      vecs.push_back(v);
   endtask

   // One valid move: confirm cycle (write + sel_clr), then the evaluation result cycle.
   task automatic mv(string n, logic [3:0] p, logic [17:0] b, logic t0, logic [1:0] w,
                     logic go, logic t1);
      add({n, "_wr"}, p, 1'b1, 1'b0, b, t0, 2'b00, 1'b0, 1'b1, 1'b0);
      add({n, "_ev"}, p, 1'b0, 1'b0, b, t1, w, go, 1'b0, 1'b0);
   endtask

   task automatic step(logic [3:0] p, logic r, logic g, logic rs);
      @(negedge clk);
      bus.pos = p; bus.ready = r; bus.new_game = g; reset = rs;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [17:0] b;
      checks = 0;
      errors = 0;
      reset = 1'b1;
      bus.pos = '0; bus.ready = 1'b0; bus.new_game = 1'b0;

      // Step 2/3: first move, occupied cell, out-of-range cell
      b = cl(4, X);
      mv("x4", 4, b, 1'b0, 2'b00, 1'b0, 1'b1);
      add("occupied", 4, 1, 0, b, 1, 2'b00, 0, 1, 1);
      add("occupied_idle", 4, 0, 0, b, 1, 2'b00, 0, 0, 0);
      add("pos9", 9, 1, 0, b, 1, 2'b00, 0, 1, 1);
      add("pos9_idle", 9, 0, 0, b, 1, 2'b00, 0, 0, 0);
      add("ng1", 0, 0, 1, '0, 0, 2'b00, 0, 0, 0);
      // Step 4: X wins on the top row
      b = cl(0, X);       mv("a_x0", 0, b, 0, 2'b00, 0, 1);
      b = b | cl(3, O);   mv("a_o3", 3, b, 1, 2'b00, 0, 0);
      b = b | cl(1, X);   mv("a_x1", 1, b, 0, 2'b00, 0, 1);
      b = b | cl(4, O);   mv("a_o4", 4, b, 1, 2'b00, 0, 0);
      b = b | cl(2, X);   mv("a_x2", 2, b, 0, 2'b01, 1, 0);
      add("over_p8", 8, 1, 0, b, 0, 2'b01, 1, 1, 0);
      add("over_p8_idle", 8, 0, 0, b, 0, 2'b01, 1, 0, 0);
      add("over_p0", 0, 1, 0, b, 0, 2'b01, 1, 1, 0);
      add("over_p0_idle", 0, 0, 0, b, 0, 2'b01, 1, 0, 0);
      add("ng2", 0, 0, 1, '0, 0, 2'b00, 0, 0, 0);
      // Step 5: full board without a line
      b = cl(0, X);       mv("d_x0", 0, b, 0, 2'b00, 0, 1);
      b = b | cl(1, O);   mv("d_o1", 1, b, 1, 2'b00, 0, 0);
      b = b | cl(2, X);   mv("d_x2", 2, b, 0, 2'b00, 0, 1);
      b = b | cl(4, O);   mv("d_o4", 4, b, 1, 2'b00, 0, 0);
      b = b | cl(3, X);   mv("d_x3", 3, b, 0, 2'b00, 0, 1);
      b = b | cl(5, O);   mv("d_o5", 5, b, 1, 2'b00, 0, 0);
      b = b | cl(7, X);   mv("d_x7", 7, b, 0, 2'b00, 0, 1);
      b = b | cl(6, O);   mv("d_o6", 6, b, 1, 2'b00, 0, 0);
      b = b | cl(8, X);   mv("d_x8", 8, b, 0, 2'b11, 1, 0);
      add("ng3", 0, 0, 1, '0, 0, 2'b00, 0, 0, 0);
      add("ng_vs_confirm", 0, 1, 1, '0, 0, 2'b00, 0, 0, 0);
      add("ng_vs_confirm_idle", 0, 0, 0, '0, 0, 2'b00, 0, 0, 0);
      // Step 6: ready held high gives exactly one write
      b = cl(0, X);
      add("hold_wr", 0, 1, 0, b, 0, 2'b00, 0, 1, 0);
      add("hold_ev", 0, 1, 0, b, 1, 2'b00, 0, 0, 0);
      for (int i = 0; i < 8; i++) add("hold", 0, 1, 0, b, 1, 2'b00, 0, 0, 0);
      add("hold_rel", 0, 0, 0, b, 1, 2'b00, 0, 0, 0);
      // O wins on the middle column
      b = b | cl(1, O);   mv("o_o1", 1, b, 1, 2'b00, 0, 0);
      b = b | cl(3, X);   mv("o_x3", 3, b, 0, 2'b00, 0, 1);
      b = b | cl(4, O);   mv("o_o4", 4, b, 1, 2'b00, 0, 0);
      b = b | cl(5, X);   mv("o_x5", 5, b, 0, 2'b00, 0, 1);
      b = b | cl(7, O);   mv("o_o7", 7, b, 1, 2'b10, 1, 1);

      // Reset state
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset_state", outs(), 24'h0);
      step(4'd0, 1'b0, 1'b0, 1'b0);
      check("reset_release", outs(), 24'h0);

      foreach (vecs[i]) begin
         step(vecs[i].pos, vecs[i].rdy, vecs[i].ng, 1'b0);
         check(vecs[i].name, outs(), {vecs[i].board, vecs[i].turn, vecs[i].winner, vecs[i].go,
                                      vecs[i].sc, vecs[i].me});
      end

      // Reset during EVAL discards the pending evaluation; reset beats new_game
      step(4'd0, 1'b0, 1'b1, 1'b0);
      step(4'd4, 1'b1, 1'b0, 1'b0);
      check("pre_reset_wr", outs(), {cl(4, X), 1'b0, 2'b00, 1'b0, 1'b1, 1'b0});
      step(4'd4, 1'b0, 1'b1, 1'b1);
      check("mid_eval_reset", outs(), 24'h0);
      step(4'd4, 1'b0, 1'b0, 1'b0);
      check("after_reset_idle", outs(), 24'h0);
      step(4'd4, 1'b1, 1'b0, 1'b0);
      check("after_reset_wr", outs(), {cl(4, X), 1'b0, 2'b00, 1'b0, 1'b1, 1'b0});
      step(4'd4, 1'b0, 1'b0, 1'b0);
      check("after_reset_ev", outs(), {cl(4, X), 1'b1, 2'b00, 1'b0, 1'b0, 1'b0});

`ifdef TURN_TIMEOUT_EN
      step(4'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 15; i++) step(4'd0, 1'b0, 1'b0, 1'b0);
      check("timeout_before", outs(), 24'h0);
      step(4'd0, 1'b0, 1'b0, 1'b0);
      check("timeout_toggle", outs(), {18'h0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0});
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
